ram_arbiter: RTL and testbench

- Shares the processor's single-port 256x8 RAM between two requesters: port 0 (CPU core) and port 1 (program loader/debug host).
- Request/grant handshake with round-robin or fixed-priority arbitration.
- Optional bus lock for atomic read-modify-write sequences, with a watchdog that forcibly releases a stuck lock.
- The RAM array is instantiated inside the block, so the block is the sole owner of program/data memory.

---
 rtl/ram_arb_pkg.sv | 15 +
 rtl/ram_sp.sv | 29 ++
 rtl/ram_arbiter.sv | 162 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types and defaults for the two-port RAM arbiter
package ram_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    localparam int PORT_CPU   = 0;
    localparam int PORT_HOST  = 1;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/ram_sp.sv
// rtl/ram_sp.sv - synchronous single-port RAM with registered read
module ram_sp
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Read port only updates on a read, so rdata holds between reads.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-requester arbiter owning the single-port program/data RAM
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int RR_EN    = 1,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              lock_timeout
);

    localparam int CNT_W = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;

    arb_state_t        state;
    logic              last;
    logic              owner;
    logic              fav_valid;
    logic              fav_port;
    logic [CNT_W-1:0]  lock_cnt;
    logic              rv0_q;
    logic              rv1_q;
    logic [DATA_W-1:0] hold0;
    logic [DATA_W-1:0] hold1;
    logic [DATA_W-1:0] ram_q;

    logic              both;
    logic              tie_pick;
    logic              owner_req;
    logic              owner_lock;
    logic              timeout;
    logic              g_any;
    logic              g_idx;
    logic              g_we;
    logic              g_lock;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;

    assign both       = req0 & req1;
    assign owner_req  = (owner == 1'(PORT_HOST)) ? req1 : req0;
    assign owner_lock = (owner == 1'(PORT_HOST)) ? lock1 : lock0;
    assign timeout    = (state == ARB_LOCKED) && (lock_cnt == CNT_W'(LOCK_MAX - 1)) && owner_lock;

    // A forced release hands the next tie to the victim, overriding the rotation.
    assign tie_pick = fav_valid ? fav_port : ((RR_EN != 0) ? ~last : 1'b0);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            case (state)
                ARB_IDLE: begin
                    if (both) begin
                        gnt0 = ~tie_pick;
                        gnt1 = tie_pick;
                    end else begin
                        gnt0 = req0;
                        gnt1 = req1;
                    end
                end
                ARB_LOCKED: begin
                    if (!timeout && owner_req) begin
                        gnt0 = ~owner;
                        gnt1 = owner;
                    end
                end
                default: begin
                    gnt0 = 1'b0;
                    gnt1 = 1'b0;
                end
            endcase
        end
    end

    assign lock_timeout = ~reset & timeout;

    assign g_any   = gnt0 | gnt1;
    assign g_idx   = gnt1;
    assign g_we    = gnt1 ? we1 : we0;
    assign g_lock  = gnt1 ? lock1 : lock0;
    assign g_addr  = gnt1 ? addr1 : addr0;
    assign g_wdata = gnt1 ? wdata1 : wdata0;

    ram_sp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .en    (g_any),
        .we    (g_we),
        .addr  (g_addr),
        .wdata (g_wdata),
        .rdata (ram_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ARB_IDLE;
            last      <= 1'b1;
            owner     <= 1'b0;
            lock_cnt  <= '0;
            fav_valid <= 1'b0;
            fav_port  <= 1'b0;
            rv0_q     <= 1'b0;
            rv1_q     <= 1'b0;
            hold0     <= '0;
            hold1     <= '0;
        end else begin
            rv0_q <= gnt0 & ~we0;
            rv1_q <= gnt1 & ~we1;
            if (rv0_q) hold0 <= ram_q;
            if (rv1_q) hold1 <= ram_q;
            if (g_any) last <= g_idx;
            case (state)
                ARB_IDLE: begin
                    if (g_any && both) fav_valid <= 1'b0;
                    if (g_any && g_lock) begin
                        state    <= ARB_LOCKED;
                        owner    <= g_idx;
                        lock_cnt <= '0;
                    end
                end
                ARB_LOCKED: begin
                    lock_cnt <= lock_cnt + 1'b1;
                    if (timeout) begin
                        state     <= ARB_IDLE;
                        fav_valid <= 1'b1;
                        fav_port  <= ~owner;
                    end else if (!owner_lock) begin
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Read data is shown live on the return cycle and held afterwards per port.
    assign rvalid0 = rv0_q & ~reset;
    assign rvalid1 = rv1_q & ~reset;
    assign rdata0  = reset ? '0 : (rv0_q ? ram_q : hold0);
    assign rdata1  = reset ? '0 : (rv1_q ? ram_q : hold1);

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench: round-robin and fixed-priority arbiters side by side
module tb_ram_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int LM = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // index [m][p]: m = 0 round-robin instance, m = 1 fixed-priority instance
    logic          req  [2][2];
    logic          we   [2][2];
    logic          lk   [2][2];
    logic [AW-1:0] ad   [2][2];
    logic [DW-1:0] wd   [2][2];
    logic          gnt  [2][2];
    logic          rv   [2][2];
    logic [DW-1:0] rdat [2][2];
    logic          to   [2];

    for (genvar m = 0; m < 2; m++) begin : g_dut
        ram_arbiter #(
            .ADDR_W   (AW),
            .DATA_W   (DW),
            .RR_EN    ((m == 0) ? 1 : 0),
            .LOCK_MAX (LM)
        ) dut (
            .clk          (clk),
            .reset        (reset),
            .req0         (req[m][0]),
            .req1         (req[m][1]),
            .we0          (we[m][0]),
            .we1          (we[m][1]),
            .lock0        (lk[m][0]),
            .lock1        (lk[m][1]),
            .addr0        (ad[m][0]),
            .addr1        (ad[m][1]),
            .wdata0       (wd[m][0]),
            .wdata1       (wd[m][1]),
            .gnt0         (gnt[m][0]),
            .gnt1         (gnt[m][1]),
            .rvalid0      (rv[m][0]),
            .rvalid1      (rv[m][1]),
            .rdata0       (rdat[m][0]),
            .rdata1       (rdat[m][1]),
            .lock_timeout (to[m])
        );
    end

    int tests_run = 0;
    int fails = 0;

    // reference model: owner = -1 when unlocked, favour = -1 when no pending forced-release bias
    int          owner  [2];
    int          held   [2];
    int          last   [2];
    int          favour [2];
    logic [7:0]  mem    [2][256];
    bit          known  [2][256];
    bit          mrv    [2][2];
    logic [7:0]  mrd    [2][2];
    bit          mrd_ok [2][2];

    bit          og  [2][2];
    bit          orv [2][2];
    logic [7:0]  ord [2][2];
    bit          oto [2];
    bit          eg  [2][2];
    bit          pend [2][2];

    typedef struct {
        bit         r0, r1, w0, w1, l0, l1;
        logic [7:0] a0, a1, d0, d1;
        bit         rr_g0, rr_g1, fp_g0, fp_g1;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic predict(input int m, output bit e0, output bit e1, output bit eto);
        int w;
        e0 = 0; e1 = 0; eto = 0;
        if (reset) return;
        if (owner[m] >= 0) begin
            if (held[m] == LM - 1 && lk[m][owner[m]]) eto = 1;
            else if (req[m][owner[m]]) begin
                if (owner[m] == 0) e0 = 1; else e1 = 1;
            end
        end else if (req[m][0] && req[m][1]) begin
            if (favour[m] >= 0) w = favour[m];
            else if (m == 0) w = 1 - last[m];
            else w = 0;
            if (w == 0) e0 = 1; else e1 = 1;
        end else begin
            e0 = req[m][0];
            e1 = req[m][1];
        end
    endtask

    task automatic advance(input int m);
        bit e0, e1, eto;
        int gp;
        predict(m, e0, e1, eto);
        if (reset) begin
            owner[m] = -1; held[m] = 0; last[m] = 1; favour[m] = -1;
            for (int p = 0; p < 2; p++) begin
                mrv[m][p] = 0; mrd[m][p] = 8'h00; mrd_ok[m][p] = 1;
            end
            return;
        end
        gp = e0 ? 0 : (e1 ? 1 : -1);
        mrv[m][0] = 0;
        mrv[m][1] = 0;
        if (gp >= 0) begin
            if (we[m][gp]) begin
                mem[m][ad[m][gp]] = wd[m][gp];
                known[m][ad[m][gp]] = 1;
            end else begin
                mrv[m][gp]    = 1;
                mrd[m][gp]    = mem[m][ad[m][gp]];
                mrd_ok[m][gp] = known[m][ad[m][gp]];
            end
        end
        if (owner[m] >= 0) begin
            if (eto) begin
                favour[m] = 1 - owner[m];
                owner[m] = -1;
            end else if (!lk[m][owner[m]]) owner[m] = -1;
            else held[m]++;
            if (gp >= 0) last[m] = gp;
        end else if (gp >= 0) begin
            if (req[m][0] && req[m][1]) favour[m] = -1;
            last[m] = gp;
            if (lk[m][gp]) begin
                owner[m] = gp;
                held[m] = 0;
            end
        end
    endtask

    task automatic step();
        bit e0, e1, eto;
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            predict(m, e0, e1, eto);
            eg[m][0] = e0;
            eg[m][1] = e1;
            for (int p = 0; p < 2; p++) begin
                og[m][p]  = gnt[m][p];
                orv[m][p] = rv[m][p];
                ord[m][p] = rdat[m][p];
            end
            oto[m] = to[m];
            chk($sformatf("gnt0[m%0d]", m), int'(gnt[m][0]), int'(e0));
            chk($sformatf("gnt1[m%0d]", m), int'(gnt[m][1]), int'(e1));
            chk($sformatf("lock_timeout[m%0d]", m), int'(to[m]), int'(eto));
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("rvalid%0d[m%0d]", p, m), int'(rv[m][p]), reset ? 0 : int'(mrv[m][p]));
                if (reset) chk($sformatf("rdata%0d_rst[m%0d]", p, m), int'(rdat[m][p]), 0);
                else if (mrd_ok[m][p]) chk($sformatf("rdata%0d[m%0d]", p, m), int'(rdat[m][p]), int'(mrd[m][p]));
            end
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) advance(m);
        #1;
    endtask

    task automatic drive_both(input int p, input bit r, input bit w, input bit l,
                              input logic [7:0] a, input logic [7:0] d);
        for (int m = 0; m < 2; m++) begin
            req[m][p] = r; we[m][p] = w; lk[m][p] = l; ad[m][p] = a; wd[m][p] = d;
        end
    endtask

    task automatic idle_both();
        drive_both(0, 0, 0, 0, 8'h00, 8'h00);
        drive_both(1, 0, 0, 0, 8'h00, 8'h00);
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            owner[m] = -1; held[m] = 0; last[m] = 1; favour[m] = -1;
            for (int p = 0; p < 2; p++) begin
                mrv[m][p] = 0; mrd[m][p] = 8'h00; mrd_ok[m][p] = 0; pend[m][p] = 0;
            end
            for (int a = 0; a < 256; a++) begin
                known[m][a] = 0; mem[m][a] = 8'h00;
            end
        end
        idle_both();
        drive_both(0, 1, 0, 0, 8'h01, 8'h00);
        drive_both(1, 1, 0, 0, 8'h02, 8'h00);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // reset state with both ports requesting
        step();
        for (int m = 0; m < 2; m++) begin
            chk("rst_gnt0", int'(og[m][0]), 0);
            chk("rst_gnt1", int'(og[m][1]), 0);
            chk("rst_rvalid0", int'(orv[m][0]), 0);
            chk("rst_rdata1", int'(ord[m][1]), 0);
        end
        idle_both();
        step();
        reset = 1'b0;

        // single requester write then read
        drive_both(1, 1, 1, 0, 8'h10, 8'hA5);
        step();
        for (int m = 0; m < 2; m++) chk("wr10_gnt1", int'(og[m][1]), 1);
        drive_both(1, 0, 0, 0, 8'h00, 8'h00);
        drive_both(0, 1, 0, 0, 8'h10, 8'h00);
        step();
        for (int m = 0; m < 2; m++) chk("rd10_gnt0", int'(og[m][0]), 1);
        idle_both();
        step();
        for (int m = 0; m < 2; m++) begin
            chk("rd10_rvalid0", int'(orv[m][0]), 1);
            chk("rd10_rdata0", int'(ord[m][0]), 8'hA5);
        end

        // table-driven: arbitration pattern after reset, then cross-port write/read
        vecs[0] = '{1,1,0,0,0,0, 8'h10,8'h10,8'h00,8'h00, 1,0, 1,0};
        vecs[1] = '{1,1,0,0,0,0, 8'h10,8'h10,8'h00,8'h00, 0,1, 1,0};
        vecs[2] = '{1,1,0,0,0,0, 8'h10,8'h10,8'h00,8'h00, 1,0, 1,0};
        vecs[3] = '{1,1,0,0,0,0, 8'h10,8'h10,8'h00,8'h00, 0,1, 1,0};
        vecs[4] = '{1,0,1,0,0,0, 8'h05,8'h00,8'h3C,8'h00, 1,0, 1,0};
        vecs[5] = '{0,1,0,0,0,0, 8'h00,8'h05,8'h00,8'h00, 0,1, 0,1};
        vecs[6] = '{0,0,0,0,0,0, 8'h00,8'h00,8'h00,8'h00, 0,0, 0,0};
        reset = 1'b1;
        idle_both();
        step();
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive_both(0, vecs[i].r0, vecs[i].w0, vecs[i].l0, vecs[i].a0, vecs[i].d0);
            drive_both(1, vecs[i].r1, vecs[i].w1, vecs[i].l1, vecs[i].a1, vecs[i].d1);
            step();
            chk($sformatf("vec%0d_rr_gnt0", i), int'(og[0][0]), int'(vecs[i].rr_g0));
            chk($sformatf("vec%0d_rr_gnt1", i), int'(og[0][1]), int'(vecs[i].rr_g1));
            chk($sformatf("vec%0d_fp_gnt0", i), int'(og[1][0]), int'(vecs[i].fp_g0));
            chk($sformatf("vec%0d_fp_gnt1", i), int'(og[1][1]), int'(vecs[i].fp_g1));
        end
        for (int m = 0; m < 2; m++) begin
            chk("xport_rvalid1", int'(orv[m][1]), 1);
            chk("xport_rdata1", int'(ord[m][1]), 8'h3C);
        end

        // atomic read-modify-write by port 1 while port 0 waits
        drive_both(1, 1, 0, 1, 8'h20, 8'h00);
        step();
        for (int m = 0; m < 2; m++) chk("atom_rd_gnt1", int'(og[m][1]), 1);
        drive_both(0, 1, 0, 0, 8'h30, 8'h00);
        drive_both(1, 1, 1, 0, 8'h21, 8'h77);
        step();
        for (int m = 0; m < 2; m++) begin
            chk("atom_wr_gnt1", int'(og[m][1]), 1);
            chk("atom_wr_gnt0", int'(og[m][0]), 0);
        end
        drive_both(1, 0, 0, 0, 8'h00, 8'h00);
        step();
        for (int m = 0; m < 2; m++) chk("atom_after_gnt0", int'(og[m][0]), 1);
        idle_both();
        step();

        // watchdog: port 0 locks then abandons the bus with lock held
        drive_both(0, 1, 0, 1, 8'h10, 8'h00);
        step();
        for (int m = 0; m < 2; m++) chk("wd_lock_gnt0", int'(og[m][0]), 1);
        drive_both(0, 0, 0, 1, 8'h10, 8'h00);
        drive_both(1, 1, 0, 0, 8'h40, 8'h00);
        for (int c = 1; c <= 17; c++) begin
            step();
            for (int m = 0; m < 2; m++) begin
                if (c == 15) chk("wd_c15_timeout", int'(oto[m]), 0);
                if (c == 16) begin
                    chk("wd_c16_timeout", int'(oto[m]), 1);
                    chk("wd_c16_gnt1", int'(og[m][1]), 0);
                end
                if (c == 17) begin
                    chk("wd_c17_gnt1", int'(og[m][1]), 1);
                    chk("wd_c17_timeout", int'(oto[m]), 0);
                end
            end
            if (c == 17) idle_both();
        end
        step();

        // reset in the cycle after a read grant
        drive_both(0, 1, 0, 0, 8'h10, 8'h00);
        step();
        reset = 1'b1;
        drive_both(0, 1, 0, 0, 8'h10, 8'h00);
        drive_both(1, 1, 0, 0, 8'h10, 8'h00);
        step();
        for (int m = 0; m < 2; m++) begin
            chk("rstmid_rvalid0", int'(orv[m][0]), 0);
            chk("rstmid_gnt0", int'(og[m][0]), 0);
            chk("rstmid_gnt1", int'(og[m][1]), 0);
        end
        reset = 1'b0;
        step();
        for (int m = 0; m < 2; m++) chk("rstmid_tie_gnt0", int'(og[m][0]), 1);
        idle_both();
        step();

        // randomized traffic, independent requesters per instance
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset = ($urandom_range(0, 299) == 0);
            for (int m = 0; m < 2; m++) begin
                for (int p = 0; p < 2; p++) begin
                    if (!pend[m][p]) begin
                        if ($urandom_range(0, 1) == 1) begin
                            pend[m][p] = 1;
                            req[m][p]  = 1;
                            we[m][p]   = 1'($urandom_range(0, 1));
                            lk[m][p]   = ($urandom_range(0, 3) == 0);
                            ad[m][p]   = 8'($urandom_range(0, 15));
                            wd[m][p]   = 8'($urandom);
                        end else begin
                            req[m][p] = 0;
                            lk[m][p]  = ($urandom_range(0, 7) == 0);
                        end
                    end
                end
            end
            step();
            for (int m = 0; m < 2; m++)
                for (int p = 0; p < 2; p++)
                    if (pend[m][p] && eg[m][p]) pend[m][p] = 0;
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
